// File: rtl/mem_pkg.sv
// Shared types and constants for the IF/LS memory arbiter.
// State/owner encodings and the byte-address legality check live here.
package mem_pkg;

    localparam int unsigned DEPTH_W_DEF = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    // Misaligned, or beyond the 2^depth_w-word array.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_w);
        return (addr[1:0] != 2'b00) || ((addr >> (depth_w + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU requesters, the arbiter and the word memory.
// slave = arbiter view; master = CPU/memory view.
interface mem_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;

    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output ls_gnt, ls_rvalid, ls_rdata, ls_err,
        output mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
        input  mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_rr_pick.sv
// Combinational 2-way selector: round-robin on ties, or fixed LS priority.
module mem_rr_pick
    import mem_pkg::*;
#(
    parameter bit LS_PRIORITY = 1'b0
) (
    input  logic if_req,
    input  logic ls_req,
    input  logic rr_last,
    output logic valid,
    output logic owner
);

    always_comb begin
        valid = if_req | ls_req;
        owner = OWN_IF;
        if (if_req && ls_req) begin
            owner = LS_PRIORITY ? OWN_LS : ~rr_last;
        end else if (ls_req) begin
            owner = OWN_LS;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one combinational-read word memory between instruction fetch and load/store.
// Each transaction is IDLE -> ACCESS (memory driven, gnt) -> RESP (rvalid).
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_W     = DEPTH_W_DEF,
    parameter bit          LS_PRIORITY = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    state_e               state_q, state_d;
    logic                 owner_q;
    logic                 we_q;
    logic                 err_q;
    logic [DEPTH_W-1:0]   idx_q;
    logic [31:0]          wdata_q;
    logic                 rr_last_q;
    logic [31:0]          if_rdata_q;
    logic [31:0]          ls_rdata_q;

    logic                 sel_valid;
    logic                 sel_owner;
    logic [31:0]          sel_addr;
    logic [31:0]          access_rdata;

    mem_rr_pick #(
        .LS_PRIORITY (LS_PRIORITY)
    ) u_pick (
        .if_req  (bus.if_req),
        .ls_req  (bus.ls_req),
        .rr_last (rr_last_q),
        .valid   (sel_valid),
        .owner   (sel_owner)
    );

    assign sel_addr = (sel_owner == OWN_LS) ? bus.ls_addr : bus.if_addr;
    // Stores and illegal accesses return zero rather than whatever the array shows.
    assign access_rdata = (we_q || err_q) ? 32'd0 : bus.mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rr_last_q  <= OWN_LS;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && sel_valid) begin
                owner_q   <= sel_owner;
                we_q      <= (sel_owner == OWN_LS) && bus.ls_we;
                err_q     <= addr_err(sel_addr, DEPTH_W);
                idx_q     <= sel_addr[DEPTH_W+1:2];
                wdata_q   <= (sel_owner == OWN_LS) ? bus.ls_wdata : 32'd0;
                rr_last_q <= sel_owner;
            end
            if (state_q == ACCESS) begin
                if (owner_q == OWN_LS) begin
                    ls_rdata_q <= access_rdata;
                end else begin
                    if_rdata_q <= access_rdata;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel_valid) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.if_gnt    = (state_q == ACCESS) && (owner_q == OWN_IF);
        bus.ls_gnt    = (state_q == ACCESS) && (owner_q == OWN_LS);
        bus.if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
        bus.ls_rvalid = (state_q == RESP) && (owner_q == OWN_LS);
        bus.if_err    = bus.if_rvalid && err_q;
        bus.ls_err    = bus.ls_rvalid && err_q;
        bus.if_rdata  = if_rdata_q;
        bus.ls_rdata  = ls_rdata_q;
        bus.mem_we    = (state_q == ACCESS) && we_q && !err_q;
        bus.mem_addr  = 32'(idx_q);
        bus.mem_wdata = wdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-schedule model checked every cycle on dut0,
// plus directed vectors with literal expectations (dut1 runs with LS priority).
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if b0 ();
    mem_arbiter_if b1 ();

    mem_arbiter #(.DEPTH_W(12), .LS_PRIORITY(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    mem_arbiter #(.DEPTH_W(12), .LS_PRIORITY(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    // Memory instance behind dut0: combinational read, write on the clock edge.
    logic [31:0] mem0 [0:4095];
    assign b0.mem_rdata = mem0[b0.mem_addr[11:0]];
    assign b1.mem_rdata = 32'h0;
    always @(posedge clk) if (b0.mem_we) mem0[b0.mem_addr[11:0]] = b0.mem_wdata;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transaction accepted at cycle c owns the port until c+3;
    // gnt is seen in cycle c+1 and the response in cycle c+2.
    logic [31:0] m_mem [0:4095];
    int          cyc = 0, free_at = 0, gnt_at = -1, rv_at = -1, wr_at = -1;
    bit          m_own, m_we, m_err, rr_last = 1'b1;
    logic [11:0] m_idx = '0;
    logic [31:0] m_wdata = '0, m_pend = '0, exp_if_rdata = '0, exp_ls_rdata = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            free_at = 0; gnt_at = -1; rv_at = -1; wr_at = -1;
            rr_last = 1'b1; exp_if_rdata = '0; exp_ls_rdata = '0;
        end else begin
            logic [31:0] a;
            bit win;
            if (cyc == wr_at) m_mem[m_idx] = m_wdata;
            if (cyc >= free_at && (b0.if_req || b0.ls_req)) begin
                if (b0.if_req && b0.ls_req) win = !rr_last;
                else win = b0.ls_req;
                a       = win ? b0.ls_addr : b0.if_addr;
                m_own   = win;
                m_we    = win && b0.ls_we;
                m_err   = (a % 4 != 0) || (a >= 32'h4000);
                m_idx   = a[13:2];
                m_wdata = win ? b0.ls_wdata : 32'h0;
                m_pend  = (m_we || m_err) ? 32'h0 : m_mem[m_idx];
                gnt_at  = cyc + 1;
                rv_at   = cyc + 2;
                free_at = cyc + 3;
                wr_at   = (m_we && !m_err) ? cyc + 1 : -1;
                rr_last = win;
            end
            cyc++;
            if (cyc == rv_at) begin
                if (m_own) exp_ls_rdata = m_pend;
                else exp_if_rdata = m_pend;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            bit g, r;
            g = (cyc == gnt_at);
            r = (cyc == rv_at);
            chk("m.if_gnt", 32'(b0.if_gnt), 32'(g && !m_own));
            chk("m.ls_gnt", 32'(b0.ls_gnt), 32'(g && m_own));
            chk("m.mem_we", 32'(b0.mem_we), 32'(g && m_we && !m_err));
            if (g) chk("m.mem_addr", b0.mem_addr, 32'(m_idx));
            if (g && m_we && !m_err) chk("m.mem_wdata", b0.mem_wdata, m_wdata);
            chk("m.if_rvalid", 32'(b0.if_rvalid), 32'(r && !m_own));
            chk("m.ls_rvalid", 32'(b0.ls_rvalid), 32'(r && m_own));
            chk("m.if_err", 32'(b0.if_err), 32'(r && !m_own && m_err));
            chk("m.ls_err", 32'(b0.ls_err), 32'(r && m_own && m_err));
            chk("m.if_rdata", b0.if_rdata, exp_if_rdata);
            chk("m.ls_rdata", b0.ls_rdata, exp_ls_rdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ls_set(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
        b0.ls_req = req; b0.ls_we = we; b0.ls_addr = a; b0.ls_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem0[i] = 32'h0;
            m_mem[i] = 32'h0;
        end
        mem0[3] = 32'hDEADBEEF; m_mem[3] = 32'hDEADBEEF;
        mem0[8] = 32'h11111111; m_mem[8] = 32'h11111111;
        b0.if_req = 0; b0.if_addr = 0; ls_set(0, 0, 0, 0);
        b1.if_req = 0; b1.if_addr = 0; b1.ls_req = 0; b1.ls_we = 0;
        b1.ls_addr = 0; b1.ls_wdata = 0;

        #1 reset = 1'b1;
        #1 cmp_en = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst.if_gnt", 32'(b0.if_gnt), 0);
        chk("rst.ls_rvalid", 32'(b0.ls_rvalid), 0);
        chk("rst.mem_we", 32'(b0.mem_we), 0);
        chk("rst.mem_addr", b0.mem_addr, 0);
        chk("rst.if_rdata", b0.if_rdata, 0);

        // Single IF fetch from word 3
        b0.if_req = 1; b0.if_addr = 32'h0C;
        step();
        chk("if.gnt", 32'(b0.if_gnt), 1);
        chk("if.mem_addr", b0.mem_addr, 3);
        b0.if_req = 0;
        step();
        chk("if.rvalid", 32'(b0.if_rvalid), 1);
        chk("if.rdata", b0.if_rdata, 32'hDEADBEEF);
        chk("if.err", 32'(b0.if_err), 0);
        step();

        // Store then load at 0x10
        ls_set(1, 1, 32'h10, 32'h12345678);
        step();
        chk("st.gnt", 32'(b0.ls_gnt), 1);
        chk("st.mem_we", 32'(b0.mem_we), 1);
        chk("st.mem_addr", b0.mem_addr, 4);
        ls_set(0, 0, 32'h10, 0);
        step();
        chk("st.mem_we_off", 32'(b0.mem_we), 0);
        chk("st.rvalid", 32'(b0.ls_rvalid), 1);
        chk("st.rdata", b0.ls_rdata, 0);
        chk("st.mem4", mem0[4], 32'h12345678);
        step();
        ls_set(1, 0, 32'h10, 0);
        step();
        ls_set(0, 0, 0, 0);
        step();
        chk("ld.rvalid", 32'(b0.ls_rvalid), 1);
        chk("ld.rdata", b0.ls_rdata, 32'h12345678);
        step();

        // Illegal stores: misaligned, then past the end of the array
        ls_set(1, 1, 32'h13, 32'hA5A5A5A5);
        step();
        chk("mis.mem_we", 32'(b0.mem_we), 0);
        ls_set(0, 0, 0, 0);
        step();
        chk("mis.err", 32'(b0.ls_err), 1);
        chk("mis.mem4", mem0[4], 32'h12345678);
        step();
        ls_set(1, 1, 32'h0000_4000, 32'hA5A5A5A5);
        step();
        chk("oor.mem_we", 32'(b0.mem_we), 0);
        ls_set(0, 0, 0, 0);
        step();
        chk("oor.err", 32'(b0.ls_err), 1);
        chk("oor.mem0", mem0[0], 32'h0);
        step();

        // Contention: round-robin on dut0, LS priority on dut1
        b0.if_req = 1; b0.if_addr = 32'h0C; ls_set(1, 0, 32'h10, 0);
        b1.if_req = 1; b1.ls_req = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr.if_gnt", 32'(b0.if_gnt), 32'(k % 2 == 0));
            chk("rr.ls_gnt", 32'(b0.ls_gnt), 32'(k % 2 == 1));
            chk("pri.ls_gnt", 32'(b1.ls_gnt), 1);
            chk("pri.if_gnt", 32'(b1.if_gnt), 0);
            if (k == 3) begin
                b0.if_req = 0; ls_set(0, 0, 0, 0);
                b1.if_req = 0; b1.ls_req = 0;
            end
            step();
            if (k < 3) step();
        end
        step();

        // Reset during the ACCESS cycle of a store to word 8
        ls_set(1, 1, 32'h20, 32'hCAFEF00D);
        step();
        chk("ra.mem_we_pre", 32'(b0.mem_we), 1);
        #2 reset = 1'b1;
        #1;
        chk("ra.mem_we", 32'(b0.mem_we), 0);
        chk("ra.ls_gnt", 32'(b0.ls_gnt), 0);
        ls_set(0, 0, 0, 0);
        step();
        reset = 1'b0;
        chk("ra.no_rvalid", 32'(b0.ls_rvalid), 0);
        chk("ra.mem8", mem0[8], 32'h11111111);
        step();
        chk("ra.no_rvalid2", 32'(b0.ls_rvalid), 0);
        b0.if_req = 1; b0.if_addr = 32'h0C; ls_set(1, 0, 32'h20, 0);
        step();
        chk("ra.if_first", 32'(b0.if_gnt), 1);
        chk("ra.ls_wait", 32'(b0.ls_gnt), 0);
        b0.if_req = 0;
        step();
        chk("ra.if_rdata", b0.if_rdata, 32'hDEADBEEF);
        step();
        step();
        ls_set(0, 0, 0, 0);
        step();
        chk("ra.ld8", b0.ls_rdata, 32'h11111111);
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
